// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and pipeline-control unit for a non-forwarding 5-stage RV32I pipeline.
// A three-entry shift-register scoreboard (EX, MEM, WB) records the destination
// register of every in-flight instruction. The decode-stage source registers
// are compared against it. The unit drives stall/flush controls for the PC,
// IF/ID and ID/EX registers, and redirects the pipeline on a taken
// branch/jump resolved in EX.
//
// Control priority: hold > branch redirect > data hazard.
//
// Parameters
//   REGFILE_BYPASS : 1 = register file is write-before-read (WB never hazards)
//                    0 = a WB-stage producer also stalls
//   ADDR_W         : register address width
//
// Ports
//   i_clk          : clock
//   i_rst          : synchronous active-low reset
//   i_insn_vld_d   : decode slot holds a valid instruction
//   i_rs1_addr_d   : decode rs1 address
//   i_rs2_addr_d   : decode rs2 address
//   i_rs1_use_d    : decode instruction reads rs1
//   i_rs2_use_d    : decode instruction reads rs2
//   i_rd_addr_d    : decode destination address
//   i_rd_wren_d    : decode instruction writes rd
//   i_pc_sel_e     : branch/jump taken, resolved in EX
//   i_hold         : global freeze (e.g. LSU wait)
//   o_stall_f      : hold PC register
//   o_stall_d      : hold IF/ID register
//   o_flush_d      : clear IF/ID register
//   o_flush_e      : load bubble into ID/EX register
//   o_stall_cnt    : hazard-stall cycle counter  (HAZARD_PERF_CNT_EN only)
//   o_flush_cnt    : redirect cycle counter      (HAZARD_PERF_CNT_EN only)
//
// Optional feature macro: HAZARD_PERF_CNT_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int REGFILE_BYPASS = 1,
    parameter int ADDR_W         = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_insn_vld_d,
    input  logic [ADDR_W-1:0] i_rs1_addr_d,
    input  logic [ADDR_W-1:0] i_rs2_addr_d,
    input  logic              i_rs1_use_d,
    input  logic              i_rs2_use_d,
    input  logic [ADDR_W-1:0] i_rd_addr_d,
    input  logic              i_rd_wren_d,
    input  logic              i_pc_sel_e,
    input  logic              i_hold,
    output logic              o_stall_f,
    output logic              o_stall_d,
    output logic              o_flush_d,
    output logic              o_flush_e
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       o_stall_cnt,
    output logic [31:0]       o_flush_cnt
`endif
);

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] rd;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '{vld: 1'b0, rd: '0};

    sb_entry_t r_sb_ex;
    sb_entry_t r_sb_mem;
    sb_entry_t r_sb_wb;

    logic      w_hit_ex;
    logic      w_hit_mem;
    logic      w_hit_wb;
    logic      w_hazard;
    sb_entry_t w_ex_next;

    // An entry matches when it holds a live non-x0 destination that the decode
    // instruction actually reads. Entries are only ever loaded with vld=1 when
    // rd!=0, but the rd check is kept so x0 can never hazard regardless.
    function automatic logic f_hit(input sb_entry_t e,
                                   input logic [ADDR_W-1:0] rs1, input logic use1,
                                   input logic [ADDR_W-1:0] rs2, input logic use2);
        return e.vld && (e.rd != '0) &&
               ((use1 && (e.rd == rs1)) || (use2 && (e.rd == rs2)));
    endfunction

    assign w_hit_ex  = f_hit(r_sb_ex,  i_rs1_addr_d, i_rs1_use_d, i_rs2_addr_d, i_rs2_use_d);
    assign w_hit_mem = f_hit(r_sb_mem, i_rs1_addr_d, i_rs1_use_d, i_rs2_addr_d, i_rs2_use_d);
    assign w_hit_wb  = f_hit(r_sb_wb,  i_rs1_addr_d, i_rs1_use_d, i_rs2_addr_d, i_rs2_use_d)
                       && (REGFILE_BYPASS == 0);

    assign w_hazard = i_insn_vld_d && (w_hit_ex || w_hit_mem || w_hit_wb);

    // Pipeline control. Outputs are combinational so the stall takes effect in
    // the same cycle the dependent instruction sits in decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        o_stall_f = 1'b0;
        o_stall_d = 1'b0;
        o_flush_d = 1'b0;
        o_flush_e = 1'b0;
        if (!i_rst) begin
            // all outputs stay 0 while reset is asserted
        end else if (i_hold) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
        end else if (i_pc_sel_e) begin
            // Redirect squashes the wrong-path fetch and decode instructions,
            // which also drops any hazard the decode instruction raised.
            o_flush_d = 1'b1;
            o_flush_e = 1'b1;
        end else if (w_hazard) begin
            o_stall_f = 1'b1;
            o_stall_d = 1'b1;
            o_flush_e = 1'b1;
        end
    end

    // A bubble (or a flushed wrong-path instruction) enters EX as an empty slot.
    assign w_ex_next = o_flush_e ? SB_EMPTY
                     : '{vld: i_insn_vld_d && i_rd_wren_d && (i_rd_addr_d != '0),
                         rd:  i_rd_addr_d};

    // NOTE: reset here is synchronous (sampled on i_clk), and all state uses
    // non-blocking assignments so the EX->MEM->WB shift reads pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_sb_ex  <= SB_EMPTY;
            r_sb_mem <= SB_EMPTY;
            r_sb_wb  <= SB_EMPTY;
        end else if (!i_hold) begin
            r_sb_ex  <= w_ex_next;
            r_sb_mem <= r_sb_ex;
            r_sb_wb  <= r_sb_mem;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Stall count covers hazard bubbles only; hold cycles and redirect cycles
    // are excluded because o_flush_e alone does not distinguish them.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (w_hazard && !i_hold && !i_pc_sel_e) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
            if (i_pc_sel_e && !i_hold) begin
                o_flush_cnt <= o_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl. Two instances share all inputs: dut_b1
// (REGFILE_BYPASS=1) and dut_b0 (REGFILE_BYPASS=0). Output bundles are
// compared as {stall_f, stall_d, flush_d, flush_e} against hand-computed
// values. Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 more unit later, away from the edge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_insn_vld_d;
    logic [4:0] i_rs1_addr_d;
    logic [4:0] i_rs2_addr_d;
    logic       i_rs1_use_d;
    logic       i_rs2_use_d;
    logic [4:0] i_rd_addr_d;
    logic       i_rd_wren_d;
    logic       i_pc_sel_e;
    logic       i_hold;

    logic b1_stall_f, b1_stall_d, b1_flush_d, b1_flush_e;
    logic b0_stall_f, b0_stall_d, b0_flush_d, b0_flush_e;
    logic [3:0] w_b1;
    logic [3:0] w_b0;

    int checks = 0;
    int errors = 0;

    // {stall_f, stall_d, flush_d, flush_e}
    localparam logic [3:0] IDLE   = 4'b0000;
    localparam logic [3:0] STALL  = 4'b1101;
    localparam logic [3:0] HOLD   = 4'b1100;
    localparam logic [3:0] REDIR  = 4'b0011;

    always #5 i_clk = ~i_clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] b1_stall_cnt, b1_flush_cnt, b0_stall_cnt, b0_flush_cnt;
`endif

    hazard_ctrl #(.REGFILE_BYPASS(1), .ADDR_W(5)) dut_b1 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_insn_vld_d (i_insn_vld_d),
        .i_rs1_addr_d (i_rs1_addr_d),
        .i_rs2_addr_d (i_rs2_addr_d),
        .i_rs1_use_d  (i_rs1_use_d),
        .i_rs2_use_d  (i_rs2_use_d),
        .i_rd_addr_d  (i_rd_addr_d),
        .i_rd_wren_d  (i_rd_wren_d),
        .i_pc_sel_e   (i_pc_sel_e),
        .i_hold       (i_hold),
        .o_stall_f    (b1_stall_f),
        .o_stall_d    (b1_stall_d),
        .o_flush_d    (b1_flush_d),
        .o_flush_e    (b1_flush_e)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cnt  (b1_stall_cnt),
        .o_flush_cnt  (b1_flush_cnt)
`endif
    );

    hazard_ctrl #(.REGFILE_BYPASS(0), .ADDR_W(5)) dut_b0 (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_insn_vld_d (i_insn_vld_d),
        .i_rs1_addr_d (i_rs1_addr_d),
        .i_rs2_addr_d (i_rs2_addr_d),
        .i_rs1_use_d  (i_rs1_use_d),
        .i_rs2_use_d  (i_rs2_use_d),
        .i_rd_addr_d  (i_rd_addr_d),
        .i_rd_wren_d  (i_rd_wren_d),
        .i_pc_sel_e   (i_pc_sel_e),
        .i_hold       (i_hold),
        .o_stall_f    (b0_stall_f),
        .o_stall_d    (b0_stall_d),
        .o_flush_d    (b0_flush_d),
        .o_flush_e    (b0_flush_e)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cnt  (b0_stall_cnt),
        .o_flush_cnt  (b0_flush_cnt)
`endif
    );

    assign w_b1 = {b1_stall_f, b1_stall_d, b1_flush_d, b1_flush_e};
    assign w_b0 = {b0_stall_f, b0_stall_d, b0_flush_d, b0_flush_e};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a decode instruction: valid, rs1/use, rs2/use, rd/wren.
    task automatic dec(input logic vld,
                       input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd,  input logic wr);
        i_insn_vld_d = vld;
        i_rs1_addr_d = rs1;
        i_rs1_use_d  = u1;
        i_rs2_addr_d = rs2;
        i_rs2_use_d  = u2;
        i_rd_addr_d  = rd;
        i_rd_wren_d  = wr;
    endtask

    task automatic bubble();
        dec(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Settle combinational outputs after an input change.
    task automatic settle();
        #1;
    endtask

    // Advance across one rising edge; inputs may change afterwards.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst      = 1'b0;
        i_hold     = 1'b0;
        i_pc_sel_e = 1'b0;
        bubble();
        tick();
        tick();
        i_rst = 1'b1;
    endtask

    initial begin
        // ---------------- reset forces outputs low ----------------
        i_rst      = 1'b0;
        i_pc_sel_e = 1'b0;
        i_hold     = 1'b1;
        bubble();
        tick();
        settle();
        check("rst_hold_b1", {28'd0, w_b1}, {28'd0, IDLE});
        i_hold     = 1'b0;
        i_pc_sel_e = 1'b1;
        settle();
        check("rst_pcsel_b1", {28'd0, w_b1}, {28'd0, IDLE});
        do_reset();

        // ---------------- addi x5 ; add x6,x5,x1 back-to-back ----------------
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);           // addi x5,x0,imm
        settle();
        check("b2b_c0_b1", {28'd0, w_b1}, {28'd0, IDLE});
        tick();
        dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);           // add x6,x5,x1
        settle();
        check("b2b_c1_b1", {28'd0, w_b1}, {28'd0, STALL});
        check("b2b_c1_b0", {28'd0, w_b0}, {28'd0, STALL});
        tick(); settle();
        check("b2b_c2_b1", {28'd0, w_b1}, {28'd0, STALL});
        check("b2b_c2_b0", {28'd0, w_b0}, {28'd0, STALL});
        tick(); settle();
        check("b2b_c3_b1", {28'd0, w_b1}, {28'd0, IDLE});
        check("b2b_c3_b0", {28'd0, w_b0}, {28'd0, STALL});
        tick(); settle();
        check("b2b_c4_b0", {28'd0, w_b0}, {28'd0, IDLE});
        do_reset();

        // ---------------- x0 producer/consumer never hazards ----------------
        dec(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);           // writes x0
        tick();
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1);           // reads x0
        settle();
        check("x0_b1", {28'd0, w_b1}, {28'd0, IDLE});
        check("x0_b0", {28'd0, w_b0}, {28'd0, IDLE});
        do_reset();

        // ---------------- one independent instruction in between ----------------
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);           // producer x7
        tick();
        dec(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1);           // independent
        settle();
        check("gap_ind_b1", {28'd0, w_b1}, {28'd0, IDLE});
        tick();
        dec(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd9, 1'b1);           // consumer of x7 on rs2
        settle();
        check("gap_c0_b1", {28'd0, w_b1}, {28'd0, STALL});
        check("gap_c0_b0", {28'd0, w_b0}, {28'd0, STALL});
        tick(); settle();
        check("gap_c1_b1", {28'd0, w_b1}, {28'd0, IDLE});
        check("gap_c1_b0", {28'd0, w_b0}, {28'd0, STALL});
        tick(); settle();
        check("gap_c2_b0", {28'd0, w_b0}, {28'd0, IDLE});
        do_reset();

        // ---------------- redirect beats hazard ----------------
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);           // producer x5
        tick();
        dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);           // dependent, wrong path
        i_pc_sel_e = 1'b1;
        settle();
        check("redir_b1", {28'd0, w_b1}, {28'd0, REDIR});
        tick();
        i_pc_sel_e = 1'b0;
        // correct-path instruction reads x6: would stall if the flushed
        // consumer had been recorded; x5 sits in MEM but is not read
        dec(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        settle();
        check("redir_next_b1", {28'd0, w_b1}, {28'd0, IDLE});
        do_reset();

        // ---------------- hold during a hazard ----------------
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
        settle();
        check("hold_pre_b1", {28'd0, w_b1}, {28'd0, STALL});
        tick();
        i_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("hold_%0d_b1", i), {28'd0, w_b1}, {28'd0, HOLD});
            tick();
        end
        i_hold = 1'b0;
        settle();
        check("hold_rel_b1", {28'd0, w_b1}, {28'd0, STALL});
        tick(); settle();
        check("hold_done_b1", {28'd0, w_b1}, {28'd0, IDLE});
        do_reset();

        // ---------------- reset mid-stall ----------------
        dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        tick();
        dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);
        settle();
        check("rstmid_pre_b0", {28'd0, w_b0}, {28'd0, STALL});
        tick();
        i_rst = 1'b0;
        settle();
        check("rstmid_in_b1", {28'd0, w_b1}, {28'd0, IDLE});
        check("rstmid_in_b0", {28'd0, w_b0}, {28'd0, IDLE});
        tick();
        i_rst = 1'b1;
        settle();
        check("rstmid_post_b1", {28'd0, w_b1}, {28'd0, IDLE});
        check("rstmid_post_b0", {28'd0, w_b0}, {28'd0, IDLE});
        tick();

`ifdef HAZARD_PERF_CNT_EN
        // ---------------- performance counters ----------------
        do_reset();
        settle();
        check("cnt_rst_stall", b1_stall_cnt, 32'd0);
        check("cnt_rst_flush", b1_flush_cnt, 32'd0);
        for (int k = 0; k < 3; k++) begin
            dec(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);       // producer x5
            tick();
            dec(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd6, 1'b1);       // 2 stalls, then issue
            tick(); tick(); tick();
        end
        bubble();
        i_pc_sel_e = 1'b1;
        tick();
        i_pc_sel_e = 1'b0;
        tick();
        i_pc_sel_e = 1'b1;
        tick();
        i_pc_sel_e = 1'b0;
        i_hold     = 1'b1;                                        // hold alone counts nothing
        tick();
        i_hold     = 1'b0;
        settle();
        check("cnt_stall", b1_stall_cnt, 32'd6);
        check("cnt_flush", b1_flush_cnt, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
